// File: rtl/operand_forward_unit_if.sv
// rtl/operand_forward_unit_if.sv - EX-stage operand/forwarding bundle shared by the forward unit and its driver
interface operand_forward_unit_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int NSRC  = 2,
    parameter int DEPTH = 3
);
    localparam int SW = $clog2(DEPTH + 1);

    logic                   ex_valid;
    logic [NSRC*AW-1:0]     ex_rs;
    logic [NSRC*WIDTH-1:0]  ex_regdata;
    logic                   ex_wen;
    logic [AW-1:0]          ex_rd;
    logic                   ex_is_load;
    logic [WIDTH-1:0]       ex_result;
    logic                   mem_load_valid;
    logic [WIDTH-1:0]       mem_load_data;
    logic [NSRC*WIDTH-1:0]  fwd_data;
    logic [NSRC*SW-1:0]     fwd_sel;
    logic                   stall;
    logic                   load_err;
    logic [15:0]            stall_cnt;

    modport master (
        output ex_valid, ex_rs, ex_regdata, ex_wen, ex_rd, ex_is_load, ex_result,
               mem_load_valid, mem_load_data,
        input  fwd_data, fwd_sel, stall, load_err, stall_cnt
    );

    modport slave (
        input  ex_valid, ex_rs, ex_regdata, ex_wen, ex_rd, ex_is_load, ex_result,
               mem_load_valid, mem_load_data,
        output fwd_data, fwd_sel, stall, load_err, stall_cnt
    );
endinterface

// File: rtl/operand_forward_unit.sv
// rtl/operand_forward_unit.sv - youngest-producer operand forwarding with load-use stall and in-flight history
module operand_forward_unit #(
    parameter int WIDTH      = 32,
    parameter int AW         = 5,
    parameter int NSRC       = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    operand_forward_unit_if.slave bus
);
    localparam int SW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;
    logic [AW-1:0]    rd   [DEPTH];
    logic [WIDTH-1:0] data [DEPTH];

    logic [NSRC-1:0]       unavail;
    logic [NSRC*WIDTH-1:0] fwd_data_c;
    logic [NSRC*SW-1:0]    fwd_sel_c;
    logic                  stall_c;
    logic                  fill;
    logic                  stray;
    logic                  load_err_q;
    logic [15:0]           stall_cnt_q;

    assign fill  = bus.mem_load_valid && v[LOAD_STAGE] && !rdy[LOAD_STAGE];
    assign stray = bus.mem_load_valid && !(v[LOAD_STAGE] && !rdy[LOAD_STAGE]);

    always_comb begin
        logic [AW-1:0]    rs;
        logic             hit;
        logic             hit_rdy;
        logic             hit_ls;
        logic [WIDTH-1:0] hit_data;
        logic [SW-1:0]    hit_sel;
        unavail    = '0;
        fwd_data_c = bus.ex_regdata;
        fwd_sel_c  = '0;
        for (int i = 0; i < NSRC; i++) begin
            rs       = bus.ex_rs[i*AW +: AW];
            hit      = 1'b0;
            hit_rdy  = 1'b0;
            hit_ls   = 1'b0;
            hit_data = '0;
            hit_sel  = '0;
            // scan oldest to youngest so the youngest match overwrites older ones
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (v[k] && rd[k] == rs && !(ZERO_REG != 0 && rs == '0)) begin
                    hit      = 1'b1;
                    hit_rdy  = rdy[k];
                    hit_ls   = (k == LOAD_STAGE);
                    hit_data = data[k];
                    hit_sel  = SW'(k + 1);
                end
            end
            if (hit) begin
                fwd_sel_c[i*SW +: SW] = hit_sel;
                if (hit_rdy) begin
                    fwd_data_c[i*WIDTH +: WIDTH] = hit_data;
                end else if (hit_ls && bus.mem_load_valid) begin
                    fwd_data_c[i*WIDTH +: WIDTH] = bus.mem_load_data;
                end else begin
                    unavail[i] = 1'b1;
                end
            end
        end
        stall_c = bus.ex_valid && (|unavail);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v           <= '0;
            rdy         <= '0;
            load_err_q  <= 1'b0;
            stall_cnt_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rd[k]   <= '0;
                data[k] <= '0;
            end
        end else begin
            v[0]    <= bus.ex_valid && !stall_c && bus.ex_wen;
            rd[0]   <= bus.ex_rd;
            data[0] <= bus.ex_result;
            rdy[0]  <= !bus.ex_is_load;
            // history always advances, so a stall never blocks a load fill
            for (int k = 1; k < DEPTH; k++) begin
                v[k]    <= v[k-1];
                rd[k]   <= rd[k-1];
                data[k] <= data[k-1];
                rdy[k]  <= rdy[k-1];
                if (k == LOAD_STAGE + 1 && fill) begin
                    rdy[k]  <= 1'b1;
                    data[k] <= bus.mem_load_data;
                end
            end
            if (stray) begin
                load_err_q <= 1'b1;
            end
            if (stall_c && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign bus.fwd_data  = fwd_data_c;
    assign bus.fwd_sel   = fwd_sel_c;
    assign bus.stall     = stall_c;
    assign bus.load_err  = load_err_q;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_operand_forward_unit.sv
// tb/tb_operand_forward_unit.sv - directed scoreboard bench for operand_forward_unit
module tb_operand_forward_unit;
    localparam logic [31:0] RD0 = 32'hAAAA0000;
    localparam logic [31:0] RD1 = 32'hBBBB0001;

    typedef enum int {K_STALL, K_D0, K_D1, K_S0, K_S1, K_ERR, K_CNT} kind_t;
    typedef struct {
        string       tag;
        kind_t       kind;
        logic [63:0] exp;
    } item_t;

    logic  clk;
    logic  rst_n;
    item_t sb[$];
    int    checks;
    int    errors;

    operand_forward_unit_if #(.WIDTH(32), .AW(5), .NSRC(2), .DEPTH(3)) bus ();

    operand_forward_unit #(
        .WIDTH(32), .AW(5), .NSRC(2), .DEPTH(3), .LOAD_STAGE(1), .ZERO_REG(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] observe(input kind_t k);
        case (k)
            K_STALL: return {63'd0, bus.stall};
            K_D0:    return {32'd0, bus.fwd_data[31:0]};
            K_D1:    return {32'd0, bus.fwd_data[63:32]};
            K_S0:    return {62'd0, bus.fwd_sel[1:0]};
            K_S1:    return {62'd0, bus.fwd_sel[3:2]};
            K_ERR:   return {63'd0, bus.load_err};
            default: return {48'd0, bus.stall_cnt};
        endcase
    endfunction

    task automatic expect_val(input string tag, input kind_t k, input logic [63:0] e);
        item_t it;
        it.tag  = tag;
        it.kind = k;
        it.exp  = e;
        sb.push_back(it);
    endtask

    task automatic check_now();
        item_t       it;
        logic [63:0] obs;
        while (sb.size() > 0) begin
            it  = sb.pop_front();
            obs = observe(it.kind);
            checks++;
            assert (obs === it.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic wen, input logic [4:0] rd, input logic ld,
                         input logic [31:0] res, input logic mlv, input logic [31:0] mld);
        bus.ex_valid       = valid;
        bus.ex_rs          = {rs1, rs0};
        bus.ex_regdata     = {RD1, RD0};
        bus.ex_wen         = wen;
        bus.ex_rd          = rd;
        bus.ex_is_load     = ld;
        bus.ex_result      = res;
        bus.mem_load_valid = mlv;
        bus.mem_load_data  = mld;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        expect_val("rst_stall", K_STALL, 64'd0);
        expect_val("rst_cnt", K_CNT, 64'd0);
        expect_val("rst_err", K_ERR, 64'd0);
        tick();
        rst_n = 1'b1;
        idle(1);

        // ALU forwarding and youngest-wins priority
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0, 32'h11, 1'b0, 32'd0);
        expect_val("alu_c0_stall", K_STALL, 64'd0);
        tick();
        drive(1'b1, 5'd3, 5'd0, 1'b1, 5'd3, 1'b0, 32'h22, 1'b0, 32'd0);
        expect_val("alu_c1_d0", K_D0, 64'h11);
        expect_val("alu_c1_s0", K_S0, 64'd1);
        tick();
        drive(1'b1, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        expect_val("alu_c2_d0", K_D0, 64'h22);
        expect_val("alu_c2_s0", K_S0, 64'd1);
        expect_val("alu_c2_d1", K_D1, 64'h22);
        tick();
        drive(1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        expect_val("alu_c3_d0", K_D0, 64'h22);
        expect_val("alu_c3_s0", K_S0, 64'd2);
        expect_val("alu_c3_d1", K_D1, {32'd0, RD1});
        expect_val("alu_c3_s1", K_S1, 64'd0);
        tick();
        idle(3);

        // load-use: one bubble, then same-cycle bypass, then filled entry
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd5, 1'b1, 32'h0, 1'b0, 32'd0);
        expect_val("lu_t_stall", K_STALL, 64'd0);
        tick();
        drive(1'b1, 5'd5, 5'd0, 1'b1, 5'd6, 1'b0, 32'h99, 1'b0, 32'd0);
        expect_val("lu_t1_stall", K_STALL, 64'd1);
        expect_val("lu_t1_cnt", K_CNT, 64'd0);
        tick();
        drive(1'b1, 5'd5, 5'd0, 1'b1, 5'd6, 1'b0, 32'h99, 1'b1, 32'hDEADBEEF);
        expect_val("lu_t2_stall", K_STALL, 64'd0);
        expect_val("lu_t2_d0", K_D0, 64'hDEADBEEF);
        expect_val("lu_t2_s0", K_S0, 64'd2);
        expect_val("lu_t2_cnt", K_CNT, 64'd1);
        tick();
        drive(1'b1, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        expect_val("lu_t3_d0", K_D0, 64'hDEADBEEF);
        expect_val("lu_t3_s0", K_S0, 64'd3);
        expect_val("lu_t3_d1", K_D1, 64'h99);
        expect_val("lu_t3_s1", K_S1, 64'd1);
        expect_val("lu_t3_cnt", K_CNT, 64'd1);
        expect_val("lu_t3_err", K_ERR, 64'd0);
        tick();
        idle(3);

        // zero register is never forwarded
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 32'h55, 1'b0, 32'd0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        expect_val("zr_s0", K_S0, 64'd0);
        expect_val("zr_d0", K_D0, {32'd0, RD0});
        expect_val("zr_stall", K_STALL, 64'd0);
        tick();
        idle(3);

        // two-operand mix; an unfilled load past LOAD_STAGE keeps stalling until it drops out
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd7, 1'b1, 32'd0, 1'b0, 32'd0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd8, 1'b0, 32'h7, 1'b0, 32'd0);
        tick();
        drive(1'b1, 5'd7, 5'd8, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        expect_val("mix_c2_stall", K_STALL, 64'd1);
        expect_val("mix_c2_d1", K_D1, 64'h7);
        expect_val("mix_c2_s1", K_S1, 64'd1);
        tick();
        expect_val("mix_c3_stall", K_STALL, 64'd1);
        expect_val("mix_c3_s1", K_S1, 64'd2);
        expect_val("mix_c3_cnt", K_CNT, 64'd2);
        tick();
        expect_val("mix_c4_stall", K_STALL, 64'd0);
        expect_val("mix_c4_s0", K_S0, 64'd0);
        expect_val("mix_c4_d0", K_D0, {32'd0, RD0});
        expect_val("mix_c4_cnt", K_CNT, 64'd3);
        tick();
        idle(3);

        // stray fill sets sticky load_err
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 32'h1234);
        expect_val("stray_pre_err", K_ERR, 64'd0);
        tick();
        idle(0);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        expect_val("stray_err1", K_ERR, 64'd1);
        tick();
        expect_val("stray_err2", K_ERR, 64'd1);
        tick();

        // asynchronous reset mid-stream with a stalling dependent in EX
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd1, 1'b1, 32'd0, 1'b0, 32'd0);
        tick();
        drive(1'b1, 5'd1, 5'd1, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        expect_val("pre_rst_stall", K_STALL, 64'd1);
        @(negedge clk);
        check_now();
        #2;
        rst_n = 1'b0;
        #1;
        expect_val("arst_stall", K_STALL, 64'd0);
        expect_val("arst_s0", K_S0, 64'd0);
        expect_val("arst_s1", K_S1, 64'd0);
        expect_val("arst_d0", K_D0, {32'd0, RD0});
        expect_val("arst_d1", K_D1, {32'd0, RD1});
        expect_val("arst_cnt", K_CNT, 64'd0);
        expect_val("arst_err", K_ERR, 64'd0);
        check_now();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_val("post_rst_stall", K_STALL, 64'd0);
        expect_val("post_rst_s0", K_S0, 64'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/operand_forward_unit.md
# operand_forward_unit

Parametrised operand-forwarding and load-use hazard unit for the pipelined CPU, sitting at the EX stage in place of the per-operand forwarding muxes. It keeps its own shift-register history of the DEPTH instructions that have left EX but are not yet visible in the register file. For each of NSRC source operands it selects the youngest in-flight producer, or the register-file value when there is none. It asserts `stall` when the youngest producer is a load whose data has not arrived.

## Interface
- `WIDTH`, 32: datapath width.
- `AW`, 5: register address width.
- `NSRC`, 2: number of source operands checked per EX instruction.
- `DEPTH`, 3: number of in-flight history entries (entry 0 is youngest). Legal range 1..7.
- `LOAD_STAGE`, 1: index of the entry at which load data returns. Must be < DEPTH.
- `ZERO_REG`, 1: when 1, register 0 is never forwarded and never stalls.
- SW = clog2(DEPTH+1).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `ex_valid` in 1: EX holds a real instruction.
- `ex_rs` in NSRC*AW: source register addresses; operand i is at [i*AW +: AW].
- `ex_regdata` in NSRC*WIDTH: register-file read values.
- `ex_wen` in 1: EX instruction writes a register.
- `ex_rd` in AW: destination register.
- `ex_is_load` in 1: EX instruction is a load; its result arrives later.
- `ex_result` in WIDTH: ALU result of the EX instruction; ignored when `ex_is_load`.
- `mem_load_valid` in 1: load data is returning for entry LOAD_STAGE.
- `mem_load_data` in WIDTH: returned load data.
- `fwd_data` out NSRC*WIDTH: resolved operand values.
- `fwd_sel` out NSRC*SW: per-operand source; 0 = register file, k = entry k-1.
- `stall` out 1: hold IF/ID/EX this cycle.
- `load_err` out 1: sticky; load data arrived for an entry that was not a pending load.
- `stall_cnt` out 16: saturating count of stall cycles.

## Operation
- Each entry holds: `v`, `rd`, `data`, `rdy`.
- **Match rule.** Operand i matches entry k when all of these hold:
  - `v[k]` is set and `rd[k] == rs_i`;
  - the entry was written with `wen` set;
  - not (ZERO_REG and `rs_i == 0`).
- **Selection.** Only the lowest-index matching entry is used. An older match is never used when a younger one exists.
- **Forwarded value.**
  - Matching entry is ready: `fwd_data_i = data[k]`, `fwd_sel_i = k+1`.
  - Matching entry is k == LOAD_STAGE, not ready, and `mem_load_valid` is high: forward `mem_load_data` (same-cycle bypass), `fwd_sel_i = k+1`, no stall.
  - Matching entry is not ready otherwise: operand is unavailable. `fwd_data_i` is don't-care.
  - No match: `fwd_data_i = ex_regdata_i`, `fwd_sel_i = 0`.
- **Stall.** `stall = ex_valid` AND any operand is unavailable. All outputs above are combinational from the entries and inputs.
- **History update on each clock edge.**
  - The history always shifts: entry k+1 <= entry k, and entry DEPTH-1 is dropped.
  - Entry 0 is loaded as follows:
    - stall or !`ex_valid`: a bubble (`v`=0).
    - otherwise: `v` = `ex_wen`, `rd` = `ex_rd`, `data` = `ex_result`, `rdy` = !`ex_is_load`.
  - Load fill: if `mem_load_valid` and entry LOAD_STAGE is `v` && !`rdy`, the entry lands in LOAD_STAGE+1 with `rdy`=1 and `data` = `mem_load_data`. If LOAD_STAGE == DEPTH-1 the entry is dropped.
  - Stray fill: if `mem_load_valid` and entry LOAD_STAGE is not a pending load, the data is ignored and `load_err` is set.
- `stall_cnt` increments on every cycle where `stall` is high and saturates at 16'hFFFF.
- A pending load that reaches LOAD_STAGE+1 or beyond without data stays not ready. Forwarding from it stalls until it leaves the history; the register file is then used.

## Timing
- Forwarding has zero cycles of latency (combinational).
- History, `load_err` and `stall_cnt` update on the rising edge of `clk`.
- While `rst_n` is low, regardless of the clock:
  - every `v` = 0, `load_err` = 0, `stall_cnt` = 0;
  - therefore `stall` = 0 and `fwd_sel` = 0, and `fwd_data` equals `ex_regdata`.
- Reset mid-operation discards all in-flight history; no pending load survives.
- Load-use with default parameters:
  - Load in EX at cycle t.
  - Dependent instruction in EX at t+1: stall.
  - Cycle t+2: load is in entry 1 and `mem_load_valid` is high; the dependent instruction gets `mem_load_data`, no stall.
  - Result: exactly one bubble.
- A stall inserts a bubble. Older entries keep advancing, so a stall never blocks a load fill.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-stream with entries valid, `ex_valid`=1, `ex_rs`={1,1}. Required: `stall`=0, `fwd_sel`=0, `fwd_data`=`ex_regdata`, `stall_cnt`=0 immediately.
- **ALU forwarding and priority.**
  - Stimulus: cycle 0 writes r3=0x11, cycle 1 writes r3=0x22, cycle 2 reads r3.
  - Required: `fwd_data`=0x22, `fwd_sel`=1.
  - Next cycle, with a non-writing instruction in EX: `fwd_data`=0x22, `fwd_sel`=2.
- **Load-use.**
  - Stimulus: load r5 at t, add r5 at t+1; at t+2 drive `mem_load_valid`=1 with data 0xDEADBEEF.
  - Required: `stall`=1 at t+1 only, `fwd_data`=0xDEADBEEF at t+2, `stall_cnt`=1.
- **Zero register.** Write r0=0x55, then read r0 with ZERO_REG=1. Required: `fwd_sel`=0, `fwd_data`=`ex_regdata`, no stall.
- **Stray fill.** Pulse `mem_load_valid` with no load in history. Required: `load_err` rises next edge and stays 1 until reset.
- **Two-operand mix.** Operand 0 depends on a pending load (no data), operand 1 on a ready ALU result 0x7. Required: `stall`=1, `fwd_data` for operand 1 = 0x7, `fwd_sel` for operand 1 = 1.
